// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequencer feeding an external 1-bit full adder LSB-first
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             load, last;

   assign last   = (cnt == CW'(WIDTH - 1));
   assign busy   = (state == SHIFT);
   assign done   = (state == DONE);
   assign fa_a   = busy & a_sr[0];
   assign fa_b   = busy & b_sr[0];
   assign fa_cin = busy & carry;

   // Shifting right and inserting at the MSB also covers WIDTH=1.
   always_comb begin
      sum_nx            = sum_sr >> 1;
      sum_nx[WIDTH-1]   = fa_sum;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= sum_nx;
            carry  <= fa_cout;
            cnt    <= cnt + CW'(1);
            // Result registers change only on the edge that enters DONE.
            if (last) begin
               sum  <= sum_nx;
               cout <= fa_cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // WIDTH=8 instance
   logic       start8 = 0, cin8 = 0;
   logic [7:0] a8 = 0, b8 = 0, sum8;
   logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, busy8, done8, cout8;
   assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
   assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   // WIDTH=4 instance
   logic       start4 = 0, cin4 = 0;
   logic [3:0] a4 = 0, b4 = 0, sum4;
   logic       fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4, busy4, done4, cout4;
   assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
   assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_cout(fa_cout4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   // WIDTH=1 instance
   logic       start1 = 0, cin1 = 0;
   logic [0:0] a1 = 0, b1 = 0, sum1;
   logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1, busy1, done1, cout1;
   assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
   assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   // Runs one WIDTH=8 add; glitch_at >= 0 pulses start with a=0 after that many busy cycles.
   task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      input int glitch_at, output int nbusy, output logic got_done);
      @(negedge clk);
      a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      nbusy = 0;
      got_done = 1'b0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         if (done8) begin
            got_done = 1'b1;
         end else begin
            if (busy8) nbusy++;
            if (nbusy == glitch_at) begin
               a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
            end
            @(negedge clk);
            start8 = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      total++; if ({busy8, done8, fa_a8, fa_b8, fa_cin8} !== 5'b0) $display("FAIL reset_ctrl got=%b exp=00000", {busy8, done8, fa_a8, fa_b8, fa_cin8}); else pass_cnt++;
      total++; if ({cout8, sum8} !== 9'h000) $display("FAIL reset_result got=%h exp=000", {cout8, sum8}); else pass_cnt++;
      total++; if ({busy4, done4, cout4, sum4, busy1, done1} !== 9'h000) $display("FAIL reset_small got=%h exp=000", {busy4, done4, cout4, sum4, busy1, done1}); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int   nb;
      logic gd;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      total++; if ({busy8, fa_a8, fa_b8, fa_cin8} !== 4'b1110) $display("FAIL first_bits got=%b exp=1110", {busy8, fa_a8, fa_b8, fa_cin8}); else pass_cnt++;
      nb = 1;
      gd = 1'b0;
      for (int i = 0; i < 20 && !gd; i++) begin
         @(negedge clk);
         if (done8) gd = 1'b1;
         else if (busy8) nb++;
      end
      total++; if (!gd) $display("FAIL ff01_done got=timeout exp=done"); else pass_cnt++;
      total++; if (nb !== 8) $display("FAIL ff01_busy got=%0d exp=8", nb); else pass_cnt++;
      total++; if ({cout8, sum8} !== 9'h100) $display("FAIL ff01_result got=%h exp=100", {cout8, sum8}); else pass_cnt++;
      @(negedge clk);
      total++; if ({done8, busy8} !== 2'b00) $display("FAIL done_pulse got=%b exp=00", {done8, busy8}); else pass_cnt++;
      total++; if ({cout8, sum8} !== 9'h100) $display("FAIL hold_idle got=%h exp=100", {cout8, sum8}); else pass_cnt++;

      op8(8'hA5, 8'h5A, 1'b1, -1, nb, gd);
      total++; if (!gd || {cout8, sum8} !== 9'h100) $display("FAIL a55a_result got=%h done=%b exp=100", {cout8, sum8}, gd); else pass_cnt++;
      op8(8'h12, 8'h34, 1'b0, -1, nb, gd);
      total++; if (!gd || {cout8, sum8} !== 9'h046) $display("FAIL 1234_result got=%h done=%b exp=046", {cout8, sum8}, gd); else pass_cnt++;
   endtask

   task automatic test_start_while_busy;
      int   nb;
      logic gd;
      op8(8'hA5, 8'h5A, 1'b1, 3, nb, gd);
      total++; if (nb !== 8) $display("FAIL busy_start_len got=%0d exp=8", nb); else pass_cnt++;
      total++; if (!gd || {cout8, sum8} !== 9'h100) $display("FAIL busy_start_result got=%h exp=100", {cout8, sum8}); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      logic seen;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if ({busy8, done8, fa_a8, fa_b8, fa_cin8} !== 5'b0) $display("FAIL midrst_ctrl got=%b exp=00000", {busy8, done8, fa_a8, fa_b8, fa_cin8}); else pass_cnt++;
      total++; if ({cout8, sum8} !== 9'h000) $display("FAIL midrst_result got=%h exp=000", {cout8, sum8}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL midrst_idle got=active exp=idle"); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int idx[$];
      int n;
      logic bad;
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      bad = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done8) begin
            idx.push_back(i);
            if ({cout8, sum8} !== 9'h046) bad = 1'b1;
         end
      end
      start8 = 1'b0;
      n = idx.size();
      total++; if (n !== 4) $display("FAIL b2b_count got=%0d exp=4", n); else pass_cnt++;
      if (n > 0) begin
         total++; if (idx[0] !== 9) $display("FAIL b2b_first got=%0d exp=9", idx[0]); else pass_cnt++;
      end
      for (int k = 1; k < n; k++) begin
         total++; if (idx[k] - idx[k-1] !== 9) $display("FAIL b2b_period got=%0d exp=9", idx[k] - idx[k-1]); else pass_cnt++;
      end
      total++; if (bad) $display("FAIL b2b_result got=wrong exp=046"); else pass_cnt++;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_width4_exhaustive;
      logic [4:0] exp;
      logic       gd;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int c = 0; c < 2; c++) begin
               exp = 5'(x + y + c);
               @(negedge clk);
               a4 = 4'(x); b4 = 4'(y); cin4 = c[0]; start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0;
               gd = 1'b0;
               for (int k = 0; k < 10 && !gd; k++) begin
                  if (done4) gd = 1'b1;
                  else @(negedge clk);
               end
               total++; if (!gd || {cout4, sum4} !== exp) $display("FAIL w4 a=%0d b=%0d c=%0d got=%h done=%b exp=%h", x, y, c, {cout4, sum4}, gd, exp); else pass_cnt++;
            end
         end
      end
   endtask

   task automatic test_width1;
      logic [1:0] exp;
      logic       gd;
      for (int v = 0; v < 8; v++) begin
         exp = 2'(v[2] + v[1] + v[0]);
         @(negedge clk);
         a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         gd = 1'b0;
         for (int k = 0; k < 6 && !gd; k++) begin
            if (done1) gd = 1'b1;
            else @(negedge clk);
         end
         total++; if (!gd || {cout1, sum1} !== exp) $display("FAIL w1 v=%0d got=%b done=%b exp=%b", v, {cout1, sum1}, gd, exp); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_width4_exhaustive();
      test_width1();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
